shift_lr_pipe: RTL and testbench

- Parametrised, pipelined bi-directional barrel shifter.
- Successor to the 32-bit combinational ShiftLR. Adds configurable width, rotate modes, registered pipeline stages and a valid/ready handshake with backpressure.
- Sits between operand fetch and the writeback mux in the functional unit.
- Carries a sideband tag so downstream logic can match results to requests.

---
 rtl/shift_lr_pipe_if.sv | 48 ++++
 rtl/shift_lr_pipe.sv | 183 ++++++++++++++++++
 tb/tb_shift_lr_pipe.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_lr_pipe_if.sv
// rtl/shift_lr_pipe_if.sv - operand/result handshake bundle for shift_lr_pipe
//
// Optional macro: SHIFT_STICKY_EN adds the STICKY result bit.
//
// Signals:
//   IN_VALID / IN_READY    operation handshake (producer -> shifter)
//   X, S, MODE, TAG        operand, shift amount, operation select, sideband tag
//   OUT_VALID / OUT_READY  result handshake (shifter -> consumer)
//   Z, TAG_OUT             result and the tag it was issued with
//   STICKY                 OR of discarded bits (SHIFT_STICKY_EN only)
//
// master = producer/consumer side, slave = the shifter.
interface shift_lr_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SW = $clog2(WIDTH);

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] X;
    logic [SW-1:0]    S;
    logic [2:0]       MODE;
    logic [TAG_W-1:0] TAG;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] Z;
    logic [TAG_W-1:0] TAG_OUT;
`ifdef SHIFT_STICKY_EN
    logic             STICKY;
`endif

    modport master (
        output IN_VALID, X, S, MODE, TAG, OUT_READY,
        input  IN_READY, OUT_VALID, Z, TAG_OUT
`ifdef SHIFT_STICKY_EN
        , input STICKY
`endif
    );

    modport slave (
        input  IN_VALID, X, S, MODE, TAG, OUT_READY,
        output IN_READY, OUT_VALID, Z, TAG_OUT
`ifdef SHIFT_STICKY_EN
        , output STICKY
`endif
    );
endinterface

// File: rtl/shift_lr_pipe.sv
// rtl/shift_lr_pipe.sv - pipelined bi-directional barrel shifter with valid/ready handshake
//
// Optional macro: SHIFT_STICKY_EN adds the pipelined STICKY output.
//
// Ports:
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    shift_lr_pipe_if.slave: operation in (X, S, MODE, TAG), result out
//          (Z, TAG_OUT, STICKY), each with its own valid/ready pair
//
// The SW log-shifter levels are spread over PIPE_STAGES register stages,
// ceil(SW/PIPE_STAGES) levels per stage. One global enable advances or
// holds the whole pipe, so a stalled result stays stable on Z/TAG_OUT.
module shift_lr_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input logic            CLK,
    input logic            RST_N,
    shift_lr_pipe_if.slave bus
);
    localparam int SW     = $clog2(WIDTH);
    localparam int LPS    = (SW + PIPE_STAGES - 1) / PIPE_STAGES;
    localparam int LAST   = PIPE_STAGES - 1;
    localparam int CTRL_N = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;
    localparam logic [WIDTH-1:0] ONES = '1;

    // One log-shifter level: shift/rotate by amt according to mode.
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d, input int amt,
                                                     input logic [2:0] mode, input logic sign);
        logic [WIDTH-1:0] r;
        case (mode)
            3'b000:         r = (d >> amt) | (sign ? ~(ONES >> amt) : '0);
            3'b001:         r = d >> amt;
            3'b010, 3'b011: r = d << amt;
            3'b100:         r = (d >> amt) | (d << (WIDTH - amt));
            3'b101:         r = (d << amt) | (d >> (WIDTH - amt));
            default:        r = d;
        endcase
        return r;
    endfunction

    // Apply only the levels owned by this stage; S bits of other stages are ignored.
    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d, input logic [SW-1:0] s,
                                                     input logic [2:0] mode, input logic sign,
                                                     input int stage);
        logic [WIDTH-1:0] r;
        logic [SW-1:0]    rem;
        r = d;
        for (int k = 0; k < SW; k++) begin
            rem = s >> k;
            if ((k / LPS) == stage && rem[0]) r = shift_level(r, 1 << k, mode, sign);
        end
        return r;
    endfunction

`ifdef SHIFT_STICKY_EN
    // Bits pushed out at each non-rotating level; across all levels this
    // covers exactly the low (right) or high (left) S bits of the operand.
    function automatic logic stage_sticky(input logic [WIDTH-1:0] d, input logic [SW-1:0] s,
                                          input logic [2:0] mode, input logic sign,
                                          input int stage);
        logic [WIDTH-1:0] r;
        logic [SW-1:0]    rem;
        logic             st;
        r  = d;
        st = 1'b0;
        for (int k = 0; k < SW; k++) begin
            rem = s >> k;
            if ((k / LPS) == stage && rem[0]) begin
                if (!mode[2] && !mode[1]) st = st | (|(r & ~(ONES << (1 << k))));
                if (!mode[2] &&  mode[1]) st = st | (|(r & ~(ONES >> (1 << k))));
                r = shift_level(r, 1 << k, mode, sign);
            end
        end
        return st;
    endfunction
`endif

    logic en;

    // Stage inputs: stage 0 from the bus, stage i from stage i-1 registers.
    logic [WIDTH-1:0] stg_data  [PIPE_STAGES];
    logic [SW-1:0]    stg_s     [PIPE_STAGES];
    logic [2:0]       stg_mode  [PIPE_STAGES];
    logic             stg_sign  [PIPE_STAGES];
    logic [TAG_W-1:0] stg_tag   [PIPE_STAGES];
    logic             stg_valid [PIPE_STAGES];

    logic [WIDTH-1:0] data_d  [PIPE_STAGES], data_q  [PIPE_STAGES];
    logic [TAG_W-1:0] tag_d   [PIPE_STAGES], tag_q   [PIPE_STAGES];
    logic             valid_d [PIPE_STAGES], valid_q [PIPE_STAGES];
    // Remaining shift amount, mode and sign only need to reach the next stage.
    logic [SW-1:0]    s_d     [CTRL_N],      s_q     [CTRL_N];
    logic [2:0]       mode_d  [CTRL_N],      mode_q  [CTRL_N];
    logic             sign_d  [CTRL_N],      sign_q  [CTRL_N];
`ifdef SHIFT_STICKY_EN
    logic             stg_sticky [PIPE_STAGES];
    logic             sticky_d   [PIPE_STAGES], sticky_q [PIPE_STAGES];
`endif

    always_comb begin
        stg_data[0]  = bus.X;
        stg_s[0]     = bus.S;
        stg_mode[0]  = bus.MODE;
        stg_sign[0]  = bus.X[WIDTH-1];
        stg_tag[0]   = bus.TAG;
        stg_valid[0] = bus.IN_VALID;
        for (int i = 1; i < PIPE_STAGES; i++) begin
            stg_data[i]  = data_q[i-1];
            stg_s[i]     = s_q[i-1];
            stg_mode[i]  = mode_q[i-1];
            stg_sign[i]  = sign_q[i-1];
            stg_tag[i]   = tag_q[i-1];
            stg_valid[i] = valid_q[i-1];
        end
`ifdef SHIFT_STICKY_EN
        stg_sticky[0] = 1'b0;
        for (int i = 1; i < PIPE_STAGES; i++) stg_sticky[i] = sticky_q[i-1];
`endif
    end

    always_comb begin
        // The pipe moves as a unit whenever the output slot is free or being taken.
        en = !valid_q[LAST] || bus.OUT_READY;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            data_d[i]  = en ? stage_shift(stg_data[i], stg_s[i], stg_mode[i], stg_sign[i], i) : data_q[i];
            tag_d[i]   = en ? stg_tag[i]   : tag_q[i];
            valid_d[i] = en ? stg_valid[i] : valid_q[i];
`ifdef SHIFT_STICKY_EN
            sticky_d[i] = en ? (stg_sticky[i] | stage_sticky(stg_data[i], stg_s[i], stg_mode[i],
                                                             stg_sign[i], i))
                             : sticky_q[i];
`endif
        end
        for (int i = 0; i < CTRL_N; i++) begin
            s_d[i]    = en ? stg_s[i]    : s_q[i];
            mode_d[i] = en ? stg_mode[i] : mode_q[i];
            sign_d[i] = en ? stg_sign[i] : sign_q[i];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                data_q[i]  <= '0;
                tag_q[i]   <= '0;
                valid_q[i] <= 1'b0;
`ifdef SHIFT_STICKY_EN
                sticky_q[i] <= 1'b0;
`endif
            end
            for (int i = 0; i < CTRL_N; i++) begin
                s_q[i]    <= '0;
                mode_q[i] <= '0;
                sign_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                data_q[i]  <= data_d[i];
                tag_q[i]   <= tag_d[i];
                valid_q[i] <= valid_d[i];
`ifdef SHIFT_STICKY_EN
                sticky_q[i] <= sticky_d[i];
`endif
            end
            for (int i = 0; i < CTRL_N; i++) begin
                s_q[i]    <= s_d[i];
                mode_q[i] <= mode_d[i];
                sign_q[i] <= sign_d[i];
            end
        end
    end

    assign bus.IN_READY  = en;
    assign bus.OUT_VALID = valid_q[LAST];
    assign bus.Z         = data_q[LAST];
    assign bus.TAG_OUT   = tag_q[LAST];
`ifdef SHIFT_STICKY_EN
    assign bus.STICKY    = sticky_q[LAST];
`endif
endmodule

// File: tb/tb_shift_lr_pipe.sv
// tb/tb_shift_lr_pipe.sv - self-checking bench for shift_lr_pipe
module tb_shift_lr_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    shift_lr_pipe_if #(.WIDTH(32), .TAG_W(4)) bus ();

    shift_lr_pipe #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(4)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    function automatic logic [31:0] ref_z(input logic [31:0] x, input int s, input logic [2:0] m);
        logic [63:0] w;
        case (m)
            3'd0: begin w = {{32{x[31]}}, x} >> s; return w[31:0]; end
            3'd1: return x >> s;
            3'd2, 3'd3: return x << s;
            3'd4: begin w = {x, x} >> s; return w[31:0]; end
            3'd5: begin w = {x, x} << s; return w[63:32]; end
            default: return x;
        endcase
    endfunction

    function automatic logic ref_sticky(input logic [31:0] x, input int s, input logic [2:0] m);
        logic [63:0] mask;
        if (s == 0 || m[2]) return 1'b0;
        if (!m[1]) begin
            mask = (64'h1 << s) - 64'h1;
            return |({32'h0, x} & mask);
        end
        return |(x >> (32 - s));
    endfunction

    typedef struct {
        logic [31:0] z;
        logic [3:0]  tag;
        logic        st;
    } exp_t;

    task automatic test_reset();
        rst_n = 1'b0;
        bus.IN_VALID = 1'b0; bus.X = '0; bus.S = '0; bus.MODE = '0; bus.TAG = '0;
        bus.OUT_READY = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus.OUT_VALID); end
        n_cmp++; if (bus.Z !== 32'h0) begin n_bad++; $display("FAIL rst_z: got %h want 0", bus.Z); end
        n_cmp++; if (bus.TAG_OUT !== 4'h0) begin n_bad++; $display("FAIL rst_tag: got %h want 0", bus.TAG_OUT); end
        n_cmp++; if (bus.IN_READY !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", bus.IN_READY); end
`ifdef SHIFT_STICKY_EN
        n_cmp++; if (bus.STICKY !== 1'b0) begin n_bad++; $display("FAIL rst_sticky: got %b want 0", bus.STICKY); end
`endif
        rst_n = 1'b1;
    endtask

    logic [31:0] d_x   [5] = '{32'h80000010, 32'h80000010, 32'h80000001, 32'h80000001, 32'h1234ABCD};
    int          d_s   [5] = '{4, 4, 1, 1, 7};
    logic [2:0]  d_m   [5] = '{3'b000, 3'b001, 3'b101, 3'b100, 3'b111};
    logic [3:0]  d_tag [5] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9};
    logic [31:0] d_z   [5] = '{32'hF8000001, 32'h08000001, 32'h00000003, 32'hC0000000, 32'h1234ABCD};

    task automatic test_directed();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.OUT_READY = 1'b1; bus.IN_VALID = 1'b1;
            bus.X = d_x[i]; bus.S = 5'(d_s[i]); bus.MODE = d_m[i]; bus.TAG = d_tag[i];
            @(negedge clk);
            bus.IN_VALID = 1'b0;
            #1;
            n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL dir%0d_early_valid: got %b want 0", i, bus.OUT_VALID); end
            @(negedge clk);
            #1;
            n_cmp++; if (bus.OUT_VALID !== 1'b1) begin n_bad++; $display("FAIL dir%0d_valid: got %b want 1", i, bus.OUT_VALID); end
            n_cmp++; if (bus.Z !== d_z[i]) begin n_bad++; $display("FAIL dir%0d_z: got %h want %h", i, bus.Z, d_z[i]); end
            n_cmp++; if (bus.TAG_OUT !== d_tag[i]) begin n_bad++; $display("FAIL dir%0d_tag: got %h want %h", i, bus.TAG_OUT, d_tag[i]); end
        end
    endtask

`ifdef SHIFT_STICKY_EN
    logic [31:0] t_x  [3] = '{32'h0000000F, 32'h00000001, 32'hC0000000};
    int          t_s  [3] = '{3, 31, 1};
    logic [2:0]  t_m  [3] = '{3'b001, 3'b011, 3'b011};
    logic        t_st [3] = '{1'b1, 1'b0, 1'b1};

    task automatic test_sticky();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.OUT_READY = 1'b1; bus.IN_VALID = 1'b1;
            bus.X = t_x[i]; bus.S = 5'(t_s[i]); bus.MODE = t_m[i]; bus.TAG = 4'(i);
            @(negedge clk);
            bus.IN_VALID = 1'b0;
            @(negedge clk);
            #1;
            n_cmp++; if (bus.STICKY !== t_st[i]) begin n_bad++; $display("FAIL sticky%0d: got %b want %b", i, bus.STICKY, t_st[i]); end
            if (i == 0) begin
                n_cmp++; if (bus.Z !== 32'h1) begin n_bad++; $display("FAIL sticky0_z: got %h want 00000001", bus.Z); end
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.OUT_READY = 1'b1;
            if (c < 6) begin
                bus.IN_VALID = 1'b1; bus.X = 32'h1; bus.S = 5'(c + 1); bus.MODE = 3'b011; bus.TAG = 4'(c + 1);
            end else begin
                bus.IN_VALID = 1'b0;
            end
            #1;
            if (c < 2) begin
                n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL b2b_c%0d_valid: got %b want 0", c, bus.OUT_VALID); end
            end else begin
                n_cmp++; if (bus.OUT_VALID !== 1'b1) begin n_bad++; $display("FAIL b2b_c%0d_valid: got %b want 1", c, bus.OUT_VALID); end
                n_cmp++; if (bus.Z !== (32'h1 << (c - 1))) begin n_bad++; $display("FAIL b2b_c%0d_z: got %h want %h", c, bus.Z, 32'h1 << (c - 1)); end
                n_cmp++; if (bus.TAG_OUT !== 4'(c - 1)) begin n_bad++; $display("FAIL b2b_c%0d_tag: got %h want %h", c, bus.TAG_OUT, 4'(c - 1)); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] bx [3];
        int          bs [3];
        logic [2:0]  bm [3];
        int sent = 0, recv = 0;
        logic prev_stall = 1'b0;
        logic [31:0] prev_z = '0;
        logic [3:0]  prev_tag = '0;
        for (int i = 0; i < 3; i++) begin
            bx[i] = $urandom; bs[i] = $urandom_range(1, 31); bm[i] = 3'($urandom_range(0, 5));
        end
        for (int c = 0; c < 40 && recv < 3; c++) begin
            @(negedge clk);
            bus.OUT_READY = !(c >= 1 && c <= 5);
            if (sent < 3) begin
                bus.IN_VALID = 1'b1; bus.X = bx[sent]; bus.S = 5'(bs[sent]); bus.MODE = bm[sent]; bus.TAG = 4'(sent + 8);
            end else begin
                bus.IN_VALID = 1'b0;
            end
            #1;
            if (prev_stall) begin
                n_cmp++; if (bus.OUT_VALID !== 1'b1 || bus.Z !== prev_z || bus.TAG_OUT !== prev_tag) begin
                    n_bad++; $display("FAIL bp_hold: got v=%b z=%h t=%h want v=1 z=%h t=%h", bus.OUT_VALID, bus.Z, bus.TAG_OUT, prev_z, prev_tag);
                end
            end
            if (bus.OUT_VALID && !bus.OUT_READY) begin
                n_cmp++; if (bus.IN_READY !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", bus.IN_READY); end
            end
            if (bus.OUT_VALID && bus.OUT_READY) begin
                n_cmp++; if (recv >= 3 || bus.Z !== ref_z(bx[recv], bs[recv], bm[recv]) || bus.TAG_OUT !== 4'(recv + 8)) begin
                    n_bad++; $display("FAIL bp_result%0d: got z=%h t=%h", recv, bus.Z, bus.TAG_OUT);
                end
                recv++;
            end
            if (bus.IN_VALID && bus.IN_READY) sent++;
            prev_stall = bus.OUT_VALID && !bus.OUT_READY;
            prev_z = bus.Z; prev_tag = bus.TAG_OUT;
        end
        n_cmp++; if (recv != 3) begin n_bad++; $display("FAIL bp_count: got %0d want 3", recv); end
        bus.IN_VALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL bp_dup%0d: got valid %b want 0", c, bus.OUT_VALID); end
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] nx;
        @(negedge clk);
        bus.OUT_READY = 1'b1; bus.IN_VALID = 1'b1; bus.X = 32'hFFFF0000; bus.S = 5'd3; bus.MODE = 3'b001; bus.TAG = 4'd1;
        @(negedge clk);
        bus.X = 32'h0000FFFF; bus.TAG = 4'd2;
        @(negedge clk);
        #1;
        bus.IN_VALID = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", bus.OUT_VALID); end
        n_cmp++; if (bus.Z !== 32'h0) begin n_bad++; $display("FAIL mid_rst_z: got %h want 0", bus.Z); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nx = $urandom;
        bus.IN_VALID = 1'b1; bus.X = nx; bus.S = 5'd9; bus.MODE = 3'b101; bus.TAG = 4'hA;
        @(negedge clk);
        bus.IN_VALID = 1'b0;
        #1;
        n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL mid_stale: got valid %b want 0", bus.OUT_VALID); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.OUT_VALID !== 1'b1 || bus.Z !== ref_z(nx, 9, 3'b101) || bus.TAG_OUT !== 4'hA) begin
            n_bad++; $display("FAIL mid_new_op: got v=%b z=%h t=%h want v=1 z=%h t=a", bus.OUT_VALID, bus.Z, bus.TAG_OUT, ref_z(nx, 9, 3'b101));
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic [3:0] tag_ctr = '0;
        for (int c = 0; c < 320; c++) begin
            @(negedge clk);
            bus.OUT_READY = (c >= 300) || ($urandom_range(0, 9) < 7);
            bus.IN_VALID  = (c < 300) && ($urandom_range(0, 3) != 0);
            bus.X = $urandom; bus.S = 5'($urandom_range(0, 31)); bus.MODE = 3'($urandom_range(0, 7)); bus.TAG = tag_ctr;
            #1;
            if (bus.OUT_VALID && bus.OUT_READY) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL rnd_spurious: got result z=%h with nothing outstanding", bus.Z);
                end else begin
                    e = q.pop_front();
                    n_cmp++; if (bus.Z !== e.z) begin n_bad++; $display("FAIL rnd_z: got %h want %h", bus.Z, e.z); end
                    n_cmp++; if (bus.TAG_OUT !== e.tag) begin n_bad++; $display("FAIL rnd_tag: got %h want %h", bus.TAG_OUT, e.tag); end
`ifdef SHIFT_STICKY_EN
                    n_cmp++; if (bus.STICKY !== e.st) begin n_bad++; $display("FAIL rnd_sticky: got %b want %b", bus.STICKY, e.st); end
`endif
                end
            end
            if (bus.IN_VALID && bus.IN_READY) begin
                e.z = ref_z(bus.X, int'(bus.S), bus.MODE);
                e.tag = bus.TAG;
                e.st = ref_sticky(bus.X, int'(bus.S), bus.MODE);
                q.push_back(e);
                tag_ctr++;
            end
        end
        n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL rnd_drain: got %0d outstanding want 0", q.size()); end
        bus.IN_VALID = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
`ifdef SHIFT_STICKY_EN
        test_sticky();
`endif
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
